alu_seq_ctrl: RTL

- Sequencer that owns the 8-bit ALU (ADD/SUB/AND/OR with N/Z/C/V flags) and serves one requester through a valid/ready command/response handshake.
- Single-cycle ops pass through the ALU once.
- MUL (unsigned 8x8 -> 16) runs as an 8-iteration shift-and-add loop on the ALU adder.
- Sits between the CPU control unit and the ALU instance; the ALU stays purely combinational, and this block drives its operands and control.

---
 rtl/alu_seq_ctrl_if.sv | 23 ++
 rtl/alu_seq_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Command/response handshake bundle between a requester and the ALU sequencer.
interface alu_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer owning a combinational 8-bit ALU: single-pass ADD/SUB/AND/OR and
// an unsigned 8x8 MUL built as a shift-and-add loop over the ALU adder.
module alu_seq_ctrl #(
  parameter int unsigned MUL_ITERS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_seq_ctrl_if.slave     bus,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [1:0]        alu_control,
  input  logic [7:0]        alu_result,
  input  logic [7:0]        alu_flags
);

  localparam int unsigned     CNT_W    = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);
  localparam logic [2:0]      OP_MUL   = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [7:0]       r_a;      // operand A, doubles as multiplicand M
  logic [7:0]       r_b;      // operand B, doubles as multiplier/low product Q
  logic [7:0]       r_phi;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_err;

  logic             w_reserved;
  logic             w_c;
  logic [7:0]       w_s;
  logic [15:0]      w_prod;
  logic             w_unused;

  assign w_reserved = (r_op > OP_MUL);
  assign w_unused   = ^alu_flags[7:4];

  // One shift-add step: conditional add of M into P_hi, then shift {C,S,Q} right.
  assign w_c    = r_b[0] & alu_flags[1];
  assign w_s    = r_b[0] ? alu_result : r_phi;
  assign w_prod = {w_c, w_s, r_b[7:1]};

  // ALU drive depends only on registered state.
  always_comb begin
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_control = 2'b00;
    case (r_state)
      S_EXEC: begin
        if (!w_reserved) begin
          alu_a       = r_a;
          alu_b       = r_b;
          alu_control = r_op[1:0];
        end
      end
      S_MUL: begin
        alu_a = r_phi;
        alu_b = r_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= 3'b000;
      r_a          <= 8'h00;
      r_b          <= 8'h00;
      r_phi        <= 8'h00;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 16'h0000;
      r_rsp_flags  <= 4'h0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_state     <= (bus.req_op == OP_MUL) ? S_MUL : S_EXEC;
            r_op        <= bus.req_op;
            r_a         <= bus.req_a;
            r_b         <= bus.req_b;
            r_phi       <= 8'h00;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        S_EXEC: begin
          if (w_reserved) begin
            r_rsp_result <= 16'h0000;
            r_rsp_flags  <= 4'h0;
            r_rsp_err    <= 1'b1;
          end else begin
            r_rsp_result <= {8'h00, alu_result};
            r_rsp_flags  <= alu_flags[3:0];
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_MUL: begin
          r_phi <= w_prod[15:8];
          r_b   <= w_prod[7:0];
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_rsp_result <= w_prod;
            r_rsp_flags  <= {1'b0, (w_prod == 16'h0000), (w_prod[15:8] != 8'h00), 1'b0};
            r_rsp_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;
  assign bus.rsp_err    = r_rsp_err;

endmodule
